// File: rtl/ddr3_pkg.sv
// ddr3_pkg: shared widths and command encodings for the DDR3 app-interface blocks
package ddr3_pkg;
    localparam int APP_DATA_WIDTH = 64;
    localparam int PIX_WIDTH = 48;
    localparam int ADDR_W = 16;
    localparam int PAD_W = APP_DATA_WIDTH - PIX_WIDTH;
    localparam logic [2:0] APP_CMD_WRITE = 3'b000;
    localparam logic [2:0] APP_CMD_READ = 3'b001;
endpackage

// File: rtl/sync_fwft_fifo.sv
// sync_fwft_fifo: first-word-fall-through FIFO with count-derived full/empty
module sync_fwft_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 16,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic do_push, do_pop;
    // a full FIFO still accepts a push when the head leaves in the same cycle
    always_comb begin
        full = count == CW'(DEPTH);
        empty = count == '0;
        do_pop = pop & ~empty;
        do_push = push & (~full | do_pop);
        dout = empty ? '0 : mem[rd_ptr];
    end
    // pointers wrap naturally; occupancy tracked by count
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
        end else begin
            wr_ptr <= wr_ptr + AW'(do_push);
            rd_ptr <= rd_ptr + AW'(do_pop);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end
    // storage array, no reset needed since empty masks the head
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end
endmodule

// File: rtl/ddr3_rd_capture.sv
// ddr3_rd_capture: tags accepted reads, pairs returned beats in order, buffers {addr, pixel}
module ddr3_rd_capture
    import ddr3_pkg::*;
#(
    parameter int DEPTH = 16,
    localparam int CW = $clog2(DEPTH) + 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      wr_en,
    input  logic                      rd_en,
    input  logic [ADDR_W-1:0]         rd_addr,
    input  logic                      app_rdy,
    input  logic                      app_wdf_rdy,
    input  logic                      init_calib_complete,
    input  logic                      app_rd_data_valid,
    input  logic                      app_rd_data_end,
    input  logic [APP_DATA_WIDTH-1:0] app_rd_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [PIX_WIDTH-1:0]      out_data,
    output logic [ADDR_W-1:0]         out_addr,
    output logic                      rd_credit,
    output logic [4:0]                outstanding,
    input  logic                      err_clr,
    output logic                      err_unexp,
    output logic                      err_ovf,
    output logic                      err_fmt
);
    logic rd_acc, beat, tag_pop, out_pop;
    logic tag_full, tag_empty, out_full, out_empty;
    logic set_unexp, set_ovf, set_fmt;
    logic [ADDR_W-1:0] tag_head;
    logic [ADDR_W+PIX_WIDTH-1:0] out_head;
    logic [CW-1:0] tag_count, out_count;
    logic [CW:0] total;
    // accept decode mirrors the driver's write-over-read priority
    always_comb begin
        rd_acc = rd_en & app_rdy & init_calib_complete & ~(wr_en & app_wdf_rdy);
        beat = app_rd_data_valid;
        tag_pop = beat & ~tag_empty;
        out_pop = ~out_empty & out_ready;
        total = {1'b0, tag_count} + {1'b0, out_count};
        set_unexp = beat & tag_empty;
        set_ovf = (rd_acc & tag_full & ~tag_pop) | (tag_pop & out_full & ~out_pop);
        set_fmt = beat & ((|app_rd_data[APP_DATA_WIDTH-1 -: PAD_W]) | ~app_rd_data_end);
        out_valid = ~out_empty;
        out_addr = out_head[ADDR_W+PIX_WIDTH-1 -: ADDR_W];
        out_data = out_head[PIX_WIDTH-1:0];
        outstanding = 5'(total);
        rd_credit = total < (CW+1)'(DEPTH);
    end
    sync_fwft_fifo #(.WIDTH(ADDR_W), .DEPTH(DEPTH)) u_tag (
        .clk(clk), .rst(rst), .push(rd_acc), .pop(tag_pop), .din(rd_addr),
        .dout(tag_head), .count(tag_count), .full(tag_full), .empty(tag_empty)
    );
    sync_fwft_fifo #(.WIDTH(ADDR_W + PIX_WIDTH), .DEPTH(DEPTH)) u_out (
        .clk(clk), .rst(rst), .push(tag_pop), .pop(out_pop),
        .din({tag_head, app_rd_data[PIX_WIDTH-1:0]}),
        .dout(out_head), .count(out_count), .full(out_full), .empty(out_empty)
    );
    // sticky flags: a new event outranks a simultaneous clear
    always_ff @(posedge clk) begin
        if (rst) begin
            err_unexp <= 1'b0;
            err_ovf <= 1'b0;
            err_fmt <= 1'b0;
        end else begin
            err_unexp <= set_unexp | (err_unexp & ~err_clr);
            err_ovf <= set_ovf | (err_ovf & ~err_clr);
            err_fmt <= set_fmt | (err_fmt & ~err_clr);
        end
    end
endmodule

// File: tb/tb_ddr3_rd_capture.sv
// tb_ddr3_rd_capture: vector table, corner sequences and random traffic against a queue model
module tb_ddr3_rd_capture;
    localparam int DEPTH = 16;
    logic clk = 0, rst, wr_en, rd_en, app_rdy, app_wdf_rdy, init_calib_complete;
    logic app_rd_data_valid, app_rd_data_end, out_valid, out_ready, rd_credit;
    logic err_clr, err_unexp, err_ovf, err_fmt;
    logic [15:0] rd_addr, out_addr;
    logic [63:0] app_rd_data;
    logic [47:0] out_data;
    logic [4:0] outstanding;
    int errors = 0, checks = 0;
    logic chk_en = 0;
    logic [15:0] tq[$];
    logic [63:0] oq[$];
    logic m_unexp = 0, m_ovf = 0, m_fmt = 0;

    typedef struct {
        logic rd, wr, wdf;
        logic [15:0] addr;
        logic v, e;
        logic [63:0] d;
        logic ordy, clr;
        logic ev;
        logic [15:0] ea;
        logic [47:0] ed;
        logic [4:0] eo;
        logic [2:0] eerr;
    } vec_t;
    vec_t vq[$];

    ddr3_rd_capture #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en), .rd_addr(rd_addr),
        .app_rdy(app_rdy), .app_wdf_rdy(app_wdf_rdy), .init_calib_complete(init_calib_complete),
        .app_rd_data_valid(app_rd_data_valid), .app_rd_data_end(app_rd_data_end),
        .app_rd_data(app_rd_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_addr(out_addr), .rd_credit(rd_credit),
        .outstanding(outstanding), .err_clr(err_clr), .err_unexp(err_unexp),
        .err_ovf(err_ovf), .err_fmt(err_fmt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", n, a, e);
        end
    endtask

    // one edge of the reference model, computed from the current inputs
    task automatic model_step();
        logic su, so, sf;
        logic [15:0] t;
        if (rst) begin
            tq.delete();
            oq.delete();
            m_unexp = 0; m_ovf = 0; m_fmt = 0;
        end else begin
            su = 0; so = 0; sf = 0;
            if (out_ready && oq.size() > 0) void'(oq.pop_front());
            if (app_rd_data_valid) begin
                if (app_rd_data[63:48] != 0 || !app_rd_data_end) sf = 1;
                if (tq.size() == 0) su = 1;
                else begin
                    t = tq.pop_front();
                    if (oq.size() < DEPTH) oq.push_back({t, app_rd_data[47:0]});
                    else so = 1;
                end
            end
            if (rd_en && app_rdy && init_calib_complete && !(wr_en && app_wdf_rdy)) begin
                if (tq.size() < DEPTH) tq.push_back(rd_addr);
                else so = 1;
            end
            m_unexp = su | (m_unexp & !err_clr);
            m_ovf = so | (m_ovf & !err_clr);
            m_fmt = sf | (m_fmt & !err_clr);
        end
    endtask

    task automatic check_all();
        int n;
        n = tq.size() + oq.size();
        chk("m_valid", out_valid, oq.size() > 0);
        chk("m_addr", out_addr, oq.size() > 0 ? oq[0][63:48] : 16'h0);
        chk("m_data", out_data, oq.size() > 0 ? oq[0][47:0] : 48'h0);
        chk("m_outstanding", outstanding, n[4:0]);
        chk("m_credit", rd_credit, n < DEPTH);
        chk("m_errs", {err_unexp, err_ovf, err_fmt}, {m_unexp, m_ovf, m_fmt});
    endtask

    task automatic cyc();
        model_step();
        @(posedge clk);
        #2;
        if (chk_en) check_all();
    endtask

    task automatic idle();
        rst = 0; wr_en = 0; rd_en = 0; rd_addr = 0; app_wdf_rdy = 0;
        app_rd_data_valid = 0; app_rd_data_end = 1; app_rd_data = 0;
        out_ready = 0; err_clr = 0; app_rdy = 1; init_calib_complete = 1;
    endtask

    task automatic add(input logic rd, wr, wdf, input logic [15:0] addr, input logic v, e,
                       input logic [63:0] d, input logic ordy, clr, input logic ev,
                       input logic [15:0] ea, input logic [47:0] ed, input logic [4:0] eo,
                       input logic [2:0] eerr);
        vq.push_back('{rd, wr, wdf, addr, v, e, d, ordy, clr, ev, ea, ed, eo, eerr});
    endtask

    initial begin
        int n;
        idle();
        rst = 1;
        cyc(); cyc();
        chk_en = 1;
        rst = 0;
        chk("rst_valid", out_valid, 0);
        chk("rst_outstanding", outstanding, 0);
        chk("rst_credit", rd_credit, 1);
        chk("rst_data", out_data, 0);
        chk("rst_errs", {err_unexp, err_ovf, err_fmt}, 0);

        // rd wr wdf addr v e data ordy clr | valid addr data outstanding {unexp,ovf,fmt}
        add(1,0,0,16'h0010,0,1,64'h0,0,0, 0,16'h0,48'h0,1,3'b000);
        add(1,0,0,16'h0011,0,1,64'h0,0,0, 0,16'h0,48'h0,2,3'b000);
        add(1,0,0,16'h0012,0,1,64'h0,0,0, 0,16'h0,48'h0,3,3'b000);
        add(0,0,0,16'h0,1,1,64'h0000_AAAA_0000_0001,1,0, 1,16'h0010,48'hAAAA_0000_0001,3,3'b000);
        add(0,0,0,16'h0,1,1,64'h0000_AAAA_0000_0002,1,0, 1,16'h0011,48'hAAAA_0000_0002,2,3'b000);
        add(0,0,0,16'h0,1,1,64'h0000_AAAA_0000_0003,1,0, 1,16'h0012,48'hAAAA_0000_0003,1,3'b000);
        add(0,0,0,16'h0,0,1,64'h0,1,0, 0,16'h0,48'h0,0,3'b000);
        add(1,1,1,16'h0020,0,1,64'h0,0,0, 0,16'h0,48'h0,0,3'b000);
        add(1,1,0,16'h0021,0,1,64'h0,0,0, 0,16'h0,48'h0,1,3'b000);
        add(0,0,0,16'h0,1,1,64'h0000_BBBB_0000_0009,0,0, 1,16'h0021,48'hBBBB_0000_0009,1,3'b000);
        add(0,0,0,16'h0,0,1,64'h0,1,0, 0,16'h0,48'h0,0,3'b000);
        add(0,0,0,16'h0,1,1,64'h0000_0000_0000_0007,0,0, 0,16'h0,48'h0,0,3'b100);
        add(0,0,0,16'h0,0,1,64'h0,0,1, 0,16'h0,48'h0,0,3'b000);
        add(1,0,0,16'h0030,0,1,64'h0,0,0, 0,16'h0,48'h0,1,3'b000);
        add(0,0,0,16'h0,1,1,64'h0001_0000_0000_0005,0,0, 1,16'h0030,48'h0000_0000_0005,1,3'b001);
        add(0,0,0,16'h0,0,1,64'h0,1,1, 0,16'h0,48'h0,0,3'b000);
        add(1,0,0,16'h0040,0,1,64'h0,0,0, 0,16'h0,48'h0,1,3'b000);
        add(0,0,0,16'h0,1,0,64'h0000_CCCC_0000_0011,0,1, 1,16'h0040,48'hCCCC_0000_0011,1,3'b001);
        add(0,0,0,16'h0,0,1,64'h0,1,1, 0,16'h0,48'h0,0,3'b000);
        for (int i = 0; i < vq.size(); i++) begin
            rd_en = vq[i].rd; wr_en = vq[i].wr; app_wdf_rdy = vq[i].wdf; rd_addr = vq[i].addr;
            app_rd_data_valid = vq[i].v; app_rd_data_end = vq[i].e; app_rd_data = vq[i].d;
            out_ready = vq[i].ordy; err_clr = vq[i].clr;
            cyc();
            chk($sformatf("row%0d_valid", i), out_valid, vq[i].ev);
            chk($sformatf("row%0d_addr", i), out_addr, vq[i].ea);
            chk($sformatf("row%0d_data", i), out_data, vq[i].ed);
            chk($sformatf("row%0d_outstanding", i), outstanding, vq[i].eo);
            chk($sformatf("row%0d_errs", i), {err_unexp, err_ovf, err_fmt}, vq[i].eerr);
        end
        idle();

        // fill until credit runs out, then force one more read
        n = 0;
        for (int k = 0; k < 40 && rd_credit; k++) begin
            rd_en = 1; rd_addr = 16'h0100 + 16'(n);
            cyc();
            n++;
        end
        chk("fill_count", n, DEPTH);
        chk("fill_credit", rd_credit, 0);
        chk("fill_outstanding", outstanding, 16);
        rd_addr = 16'h01FF;
        cyc();
        rd_en = 0;
        chk("force_ovf", err_ovf, 1);
        chk("force_outstanding", outstanding, 16);
        err_clr = 1; cyc(); err_clr = 0;
        for (int i = 0; i < DEPTH; i++) begin
            app_rd_data_valid = 1; app_rd_data = 64'(i);
            cyc();
        end
        app_rd_data_valid = 0;
        chk("beats_outstanding", outstanding, 16);
        out_ready = 1;
        for (int i = 0; i < DEPTH; i++) begin
            chk($sformatf("drain%0d_addr", i), out_addr, 16'h0100 + 16'(i));
            chk($sformatf("drain%0d_data", i), out_data, 48'(i));
            cyc();
        end
        chk("drain_credit", rd_credit, 1);
        chk("drain_outstanding", outstanding, 0);
        idle();

        // mid-operation reset with reads pending
        for (int i = 0; i < 5; i++) begin
            rd_en = 1; rd_addr = 16'h0200 + 16'(i);
            cyc();
        end
        rd_en = 0;
        chk("pre_rst_outstanding", outstanding, 5);
        rst = 1; cyc(); rst = 0;
        chk("mid_rst_outstanding", outstanding, 0);
        chk("mid_rst_valid", out_valid, 0);
        app_rd_data_valid = 1; app_rd_data = 64'h1234;
        cyc();
        app_rd_data_valid = 0;
        chk("late_beat_unexp", err_unexp, 1);
        chk("late_beat_valid", out_valid, 0);

        // randomized traffic against the model
        for (int k = 0; k < 3000; k++) begin
            rst = $urandom_range(0, 299) == 0;
            rd_en = $urandom_range(0, 1) == 1;
            wr_en = $urandom_range(0, 3) == 0;
            app_wdf_rdy = $urandom_range(0, 1) == 1;
            app_rdy = $urandom_range(0, 7) != 0;
            init_calib_complete = $urandom_range(0, 31) != 0;
            rd_addr = 16'($urandom());
            app_rd_data_valid = $urandom_range(0, 2) == 0;
            app_rd_data_end = $urandom_range(0, 7) != 0;
            app_rd_data = {$urandom(), $urandom()};
            if ($urandom_range(0, 7) != 0) app_rd_data[63:48] = 16'h0;
            out_ready = k < 1500 ? $urandom_range(0, 4) == 0 : $urandom_range(0, 2) != 0;
            err_clr = $urandom_range(0, 15) == 0;
            cyc();
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/ddr3_rd_capture.md
Name: ddr3_rd_capture

Overview:
- Downstream read-return stage for the DDR3 app-interface command driver (the block that turns wr_en/rd_en into app_en/app_cmd).
- Snoops the same request and ready signals to record the address of every read the driver accepts.
- Pairs each returned app_rd_data beat with its address in order, strips the 16-bit pad, and buffers {addr, 48-bit pixel} for a consumer with valid/ready.
- Gives upstream a read-issue credit and reports protocol errors.

Parameters:
- DEPTH, 16, entries in both the tag FIFO and the output FIFO; power of two, minimum 2.
- APP_DATA_WIDTH, 64, width of app_rd_data.
- PIX_WIDTH, 48, payload bits kept from each beat (app_rd_data[47:0]).
- ADDR_W, 16, width of the read address tag.

Ports:
- clk  in  1  system clock, 100 MHz DDR3 UI clock domain.
- rst  in  1  synchronous, active-high reset.
- wr_en  in  1  write request to the command driver (snooped).
- rd_en  in  1  read request to the command driver (snooped).
- rd_addr  in  16  read address presented with rd_en.
- app_rdy  in  1  controller command ready.
- app_wdf_rdy  in  1  controller write-data ready.
- init_calib_complete  in  1  calibration done.
- app_rd_data_valid  in  1  read beat valid.
- app_rd_data_end  in  1  last beat of burst.
- app_rd_data  in  64  read beat data.
- out_valid  out  1  output FIFO non-empty.
- out_ready  in  1  consumer accepts the head entry.
- out_data  out  48  pixel payload of the head entry.
- out_addr  out  16  address of the head entry.
- rd_credit  out  1  upstream may assert rd_en this cycle.
- outstanding  out  5  tag_count + out_count, range 0..DEPTH.
- err_clr  in  1  clears the sticky error flags.
- err_unexp  out  1  sticky: beat arrived with no tag pending.
- err_ovf  out  1  sticky: push into a full FIFO.
- err_fmt  out  1  sticky: pad bits [63:48] non-zero, or valid without end.

Behaviour:
- Read accepted in cycle N: rd_acc = rd_en & app_rdy & init_calib_complete & ~(wr_en & app_wdf_rdy). A simultaneous eligible write wins, matching the driver's priority.
- rd_acc pushes rd_addr into the tag FIFO at the edge ending cycle N.
- Beat: app_rd_data_valid in cycle M pops the tag head and pushes {tag, app_rd_data[47:0]} into the output FIFO at the edge ending M. out_valid rises in M+1 if the FIFO was empty.
- Tag FIFO and output FIFO are synchronous and first-word-fall-through. out_data and out_addr are driven directly from the output FIFO head.
- Pop of the output FIFO: out_valid & out_ready.
- Push and pop in the same cycle are allowed on either FIFO, including a push to a full FIFO with a concurrent pop; the count is unchanged in that case.
- Counters: tag_count and out_count are each 0..DEPTH. outstanding = tag_count + out_count.
- rd_credit = (outstanding < DEPTH). It is combinational from the counters only, with no dependence on rd_en.
- Error cases (each condition sets its sticky flag):
  - Beat with tag FIFO empty: err_unexp=1; the beat is dropped and no output push occurs.
  - rd_acc with tag FIFO full and no concurrent pop: err_ovf=1; the request is not recorded.
  - Beat with output FIFO full and no concurrent pop: err_ovf=1; the beat is dropped but the tag is still popped.
  - Beat with app_rd_data[63:48] != 0, or with app_rd_data_end == 0: err_fmt=1; the beat is still stored normally.
- Flag clearing:
  - err_clr=1 clears all flags at the next edge.
  - A new error event in the same cycle as err_clr wins, so the flag stays 1.
- Reset, whether at power-up or mid-operation:
  - Both FIFOs are emptied and all counters go to 0.
  - Outputs after reset: out_valid=0, out_data=0, out_addr=0, outstanding=0, rd_credit=1, all err_* = 0.
  - Beats returning after a mid-operation reset raise err_unexp; this is the required behaviour.
- Pointers are log2(DEPTH) bits and wrap naturally. Full/empty are derived from the counts, not from pointer compare.

Decomposition:
- Shared package ddr3_pkg: APP_DATA_WIDTH, PIX_WIDTH, ADDR_W, APP_CMD_WRITE=3'b000, APP_CMD_READ=3'b001, and the pad-width constant (64-48).
- Sub-module sync_fwft_fifo (params WIDTH, DEPTH; ports push, pop, din, dout, count, full, empty). It is instantiated twice:
  - tag FIFO, WIDTH=16;
  - output FIFO, WIDTH=64, packed {addr, pix}.
- The top level holds the accept decode, the error flags and the credit logic.

Test Plan:
- Three reads accepted (addr 0x0010, 0x0011, 0x0012), then beats 0x0000_AAAA_0000_0001..3 with out_ready=1 -> out_addr/out_data of 0x0010/0x...0001, 0x0011/...0002, 0x0012/...0003 in order; outstanding returns to 0; no errors.
- rd_en and wr_en both high with app_wdf_rdy=1 -> no tag pushed and outstanding unchanged; repeat with app_wdf_rdy=0 -> tag pushed.
- out_ready=0 while issuing reads until rd_credit=0 at outstanding=16; a 17th rd_en forced -> err_ovf=1 and outstanding stays 16; drain -> 16 entries in order, then rd_credit=1.
- Beat with no pending read -> err_unexp=1 and out_valid stays 0; err_clr pulse -> err_unexp=0 on the next cycle.
- Beat 0x0001_0000_0000_0005 with app_rd_data_end=1 -> err_fmt=1 and out_data=0x0000_0000_0005 is delivered.
- Five reads pending, rst pulsed for 1 cycle -> outstanding=0 and out_valid=0; the next beat raises err_unexp.
